// File: rtl/can_llc_tx_queue_if.sv
// ============================================================================
// Module : MA_data_request_if / MA_data_confirm_if
// Brief  : MA_data.request / MA_data.confirm bundles between LLC queue and MAC.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface MA_data_request_if;
   logic        valid;
   logic        ready;
   logic [10:0] identifier;
   logic [3:0]  dlc;
   logic [63:0] data_payload;

   modport LLC (output valid, identifier, dlc, data_payload, input ready);
   modport MAC (input valid, identifier, dlc, data_payload, output ready);
endinterface

interface MA_data_confirm_if;
   logic        valid;
   logic [10:0] identifier;
   logic        status;   // 1 = Success, 0 = No_Success

   modport LLC (input valid, identifier, status);
   modport MAC (output valid, identifier, status);
endinterface

`default_nettype wire

// File: rtl/can_llc_tx_queue.sv
// ============================================================================
// Module : can_llc_tx_queue
// Brief  : Frame FIFO feeding can_mac_tx; optional re-issue on No_Success
//          when CAN_LLC_TX_RETRY_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module can_llc_tx_queue #(
   parameter int DEPTH     = 4,
   parameter int MAX_RETRY = 3
) (
   input  wire                     clk,
   input  wire                     rst,
   input  wire                     wr_valid,
   output logic                    wr_ready,
   input  wire  [10:0]             wr_id,
   input  wire  [3:0]              wr_dlc,
   input  wire  [63:0]             wr_data,
   MA_data_request_if.LLC          ma_req,
   MA_data_confirm_if.LLC          ma_cfm,
   output logic                    cfm_valid,
   output logic [10:0]             cfm_id,
   output logic                    cfm_ok,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_RETRY < 0) begin : g_param_check
      $error("can_llc_tx_queue: DEPTH must be a power of two >= 2 and MAX_RETRY >= 0");
   end

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_REQ      = 2'd1,
      S_WAIT_CFM = 2'd2,
      S_REPORT   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            req_valid_q, req_valid_d;
   logic            ok_q, ok_d;

   logic [10:0]     id_mem   [DEPTH];
   logic [3:0]      dlc_mem  [DEPTH];
   logic [63:0]     data_mem [DEPTH];

   logic            w_push, w_pop, w_empty, w_cfm_hit;
   logic [10:0]     w_head_id;

`ifdef CAN_LLC_TX_RETRY_EN
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RW-1:0]   retry_q, retry_d;
`endif

   assign wr_ready  = (count_q != CW'(DEPTH));
   assign w_push    = wr_valid && wr_ready;
   assign w_pop     = (state_q == S_REPORT);
   assign w_empty   = (count_q == '0);
   assign w_head_id = id_mem[rptr_q];
   assign count_d   = count_q + CW'(w_push) - CW'(w_pop);
   assign w_cfm_hit = ma_cfm.valid && (ma_cfm.identifier == w_head_id);

   // Head fields stay put until the pop in REPORT, which keeps dlc stable for the MAC.
   assign ma_req.valid        = req_valid_q;
   assign ma_req.identifier   = w_empty ? 11'd0 : w_head_id;
   assign ma_req.dlc          = w_empty ? 4'd0  : dlc_mem[rptr_q];
   assign ma_req.data_payload = w_empty ? 64'd0 : data_mem[rptr_q];

   assign cfm_valid = (state_q == S_REPORT);
   assign cfm_id    = (state_q == S_REPORT) ? w_head_id : 11'd0;
   assign cfm_ok    = (state_q == S_REPORT) ? ok_q : 1'b0;
   assign count     = count_q;

   always_ff @(posedge clk) begin
      if (w_push) begin
         id_mem[wptr_q]   <= wr_id;
         dlc_mem[wptr_q]  <= (wr_dlc > 4'd8) ? 4'd8 : wr_dlc;
         data_mem[wptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         req_valid_q <= 1'b0;
         ok_q        <= 1'b0;
`ifdef CAN_LLC_TX_RETRY_EN
         retry_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         req_valid_q <= req_valid_d;
         ok_q        <= ok_d;
`ifdef CAN_LLC_TX_RETRY_EN
         retry_q     <= retry_d;
`endif
         if (w_push) wptr_q <= wptr_q + AW'(1);
         if (w_pop)  rptr_q <= rptr_q + AW'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      req_valid_d = req_valid_q;
      ok_d        = ok_q;
`ifdef CAN_LLC_TX_RETRY_EN
      retry_d     = retry_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (count_d != '0) state_d = S_REQ;
         end
         S_REQ: begin
            req_valid_d = 1'b1;
            if (req_valid_q && ma_req.ready) begin
               req_valid_d = 1'b0;
               state_d     = S_WAIT_CFM;
            end
         end
         S_WAIT_CFM: begin
            if (w_cfm_hit) begin
               if (ma_cfm.status) begin
                  ok_d    = 1'b1;
                  state_d = S_REPORT;
               end else begin
`ifdef CAN_LLC_TX_RETRY_EN
                  if (retry_q < RW'(MAX_RETRY)) begin
                     retry_d = retry_q + RW'(1);
                     state_d = S_REQ;
                  end else begin
                     ok_d    = 1'b0;
                     state_d = S_REPORT;
                  end
`else
                  ok_d    = 1'b0;
                  state_d = S_REPORT;
`endif
               end
            end
         end
         S_REPORT: begin
`ifdef CAN_LLC_TX_RETRY_EN
            retry_d = '0;
`endif
            // Fold the IDLE decision in here so a queued frame is requested one cycle after the report.
            state_d = (count_d != '0) ? S_REQ : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_can_llc_tx_queue.sv
// ============================================================================
// Module : tb_can_llc_tx_queue
// Brief  : Directed self-checking bench for can_llc_tx_queue (DEPTH = 4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_can_llc_tx_queue;

`ifdef CAN_LLC_TX_RETRY_EN
   localparam int TRIES = 4;
`else
   localparam int TRIES = 1;
`endif

   logic        clk;
   logic        rst;
   logic        wr_valid;
   logic        wr_ready;
   logic [10:0] wr_id;
   logic [3:0]  wr_dlc;
   logic [63:0] wr_data;
   logic        cfm_valid;
   logic [10:0] cfm_id;
   logic        cfm_ok;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   MA_data_request_if u_req_if ();
   MA_data_confirm_if u_cfm_if ();

   can_llc_tx_queue #(
      .DEPTH     (4),
      .MAX_RETRY (3)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_id     (wr_id),
      .wr_dlc    (wr_dlc),
      .wr_data   (wr_data),
      .ma_req    (u_req_if.LLC),
      .ma_cfm    (u_cfm_if.LLC),
      .cfm_valid (cfm_valid),
      .cfm_id    (cfm_id),
      .cfm_ok    (cfm_ok),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
      wr_valid = 1'b1;
      wr_id    = id;
      wr_dlc   = dlc;
      wr_data  = data;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic mac_handshake(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
      int n = 0;
      while (!u_req_if.valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("req_valid", u_req_if.valid, 1);
      chk("req_id_dlc", {u_req_if.identifier, u_req_if.dlc}, {id, dlc});
      chk("req_data", u_req_if.data_payload, data);
      u_req_if.ready = 1'b1;
      @(negedge clk);
      u_req_if.ready = 1'b0;
      chk("req_drop", u_req_if.valid, 0);
      repeat (2) @(negedge clk);
      chk("hold_id_dlc", {u_req_if.identifier, u_req_if.dlc}, {id, dlc});
      chk("hold_data", u_req_if.data_payload, data);
   endtask

   task automatic mac_confirm(input logic [10:0] id, input logic status, input int hold,
                              input int exp_pulses, input logic [10:0] exp_id,
                              input logic exp_ok, input int exp_count);
      int          pulses = 0;
      logic [10:0] got_id = '0;
      logic        got_ok = 1'b0;
      u_cfm_if.valid      = 1'b1;
      u_cfm_if.identifier = id;
      u_cfm_if.status     = status;
      for (int i = 0; i < hold + 3; i++) begin
         @(negedge clk);
         if (cfm_valid) begin
            pulses++;
            got_id = cfm_id;
            got_ok = cfm_ok;
         end
         if (i == hold - 1) u_cfm_if.valid = 1'b0;
      end
      chk("cfm_pulses", 64'(pulses), 64'(exp_pulses));
      if (exp_pulses > 0) begin
         chk("cfm_id", got_id, exp_id);
         chk("cfm_ok", got_ok, exp_ok);
      end
      chk("count_after_cfm", count, 64'(exp_count));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] d;
      logic        saw_cfm, saw_req;
      rst                 = 1'b1;
      wr_valid            = 1'b0;
      wr_id               = '0;
      wr_dlc              = '0;
      wr_data             = '0;
      u_req_if.ready      = 1'b0;
      u_cfm_if.valid      = 1'b0;
      u_cfm_if.identifier = '0;
      u_cfm_if.status     = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_req_valid", u_req_if.valid, 0);
      chk("rst_req_fields", {u_req_if.identifier, u_req_if.dlc, u_req_if.data_payload}, 0);
      chk("rst_cfm", {cfm_valid, cfm_id, cfm_ok}, 0);
      chk("rst_count", count, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single frame, Success confirm held 16 cycles
      push(11'h123, 4'd2, 64'hA55A << 48);
      chk("t1_count", count, 1);
      chk("t1_valid_low", u_req_if.valid, 0);
      @(negedge clk);
      chk("t2_valid_high", u_req_if.valid, 1);
      mac_handshake(11'h123, 4'd2, 64'hA55A << 48);
      mac_confirm(11'h123, 1'b1, 16, 1, 11'h123, 1'b1, 0);

      // Fill with MAC not ready, then drain in order
      for (int i = 0; i < 4; i++) begin
         d = 64'(8'hA0 + i) << 56;
         push(11'h010 + 11'(i), 4'(i + 1), d);
      end
      chk("full_wr_ready", wr_ready, 0);
      chk("full_count", count, 4);
      push(11'h014, 4'd5, 64'hFF);
      chk("full_5th_rejected", count, 4);
      chk("req_held_no_ready", u_req_if.valid, 1);
      for (int i = 0; i < 4; i++) begin
         d = 64'(8'hA0 + i) << 56;
         mac_handshake(11'h010 + 11'(i), 4'(i + 1), d);
         mac_confirm(11'h010 + 11'(i), 1'b1, 3, 1, 11'h010 + 11'(i), 1'b1, 3 - i);
      end
      repeat (6) @(negedge clk);
      chk("drained_no_req", u_req_if.valid, 0);
      chk("drained_fields", {u_req_if.identifier, u_req_if.dlc}, 0);

      // DLC clamp
      push(11'h055, 4'd12, 64'h0102030405060708);
      mac_handshake(11'h055, 4'd8, 64'h0102030405060708);
      mac_confirm(11'h055, 1'b1, 2, 1, 11'h055, 1'b1, 0);

      // No_Success: retried when the retry feature is built in, else dropped at once
      push(11'h7FF, 4'd8, 64'hDEADBEEF00000000);
      for (int i = 0; i < TRIES; i++) begin
         mac_handshake(11'h7FF, 4'd8, 64'hDEADBEEF00000000);
         if (i == TRIES - 1)
            mac_confirm(11'h7FF, 1'b0, 4, 1, 11'h7FF, 1'b0, 0);
         else
            mac_confirm(11'h7FF, 1'b0, 4, 0, 11'h7FF, 1'b0, 1);
      end
      repeat (6) @(negedge clk);
      chk("retry_no_extra_req", u_req_if.valid, 0);

      // Stale confirm is ignored
      push(11'h002, 4'd1, 64'h11 << 56);
      mac_handshake(11'h002, 4'd1, 64'h11 << 56);
      mac_confirm(11'h001, 1'b1, 4, 0, 11'h0, 1'b0, 1);
      chk("stale_no_req", u_req_if.valid, 0);
      mac_confirm(11'h002, 1'b1, 2, 1, 11'h002, 1'b1, 0);

      // Reset mid-frame with 3 frames queued
      push(11'h201, 4'd3, 64'h1);
      push(11'h202, 4'd3, 64'h2);
      push(11'h203, 4'd3, 64'h3);
      mac_handshake(11'h201, 4'd3, 64'h1);
      chk("pre_rst_count", count, 3);
      rst = 1'b1;
      #1;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_wr_ready", wr_ready, 1);
      chk("mid_rst_req", {u_req_if.valid, u_req_if.identifier, u_req_if.dlc, u_req_if.data_payload}, 0);
      chk("mid_rst_cfm", {cfm_valid, cfm_id, cfm_ok}, 0);
      @(negedge clk);
      rst = 1'b0;
      saw_cfm = 1'b0;
      saw_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (cfm_valid) saw_cfm = 1'b1;
         if (u_req_if.valid) saw_req = 1'b1;
      end
      chk("post_rst_no_cfm", saw_cfm, 0);
      chk("post_rst_no_req", saw_req, 0);
      chk("post_rst_count", count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
